wb_unit: RTL

- Writeback stage directly upstream of the 32x32 register file; sole driver of its regwr, rw and busW inputs.
- Accepts one retiring instruction per valid/ready handshake from the memory stage and selects ALU result, PC+4 or load data.
- For loads, waits a variable number of cycles for memory read data, then aligns and sign- or zero-extends it.
- Presents a registered write that stays stable over the following negedge, when the register file samples it.

---
 rtl/wb_unit_if.sv | 47 ++++
 rtl/wb_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_unit_if.sv
// Bundle of the memory-stage handshake, load-data return and register-file write port of wb_unit.
// The fwd_*/load_pending bypass signals exist only when WB_FWD_EN is defined.
interface wb_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_regwr;
  logic [1:0]      in_wbsel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc4;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            regwr;
  logic [4:0]      rw;
  logic [XLEN-1:0] busW;
  logic            misalign_err;
  logic            timeout_err;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            load_pending;
`endif

  // Upstream/system side: memory stage, data memory and register file.
  modport master (
    output in_valid, in_rd, in_regwr, in_wbsel, in_funct3, in_alu, in_pc4,
    output mem_rvalid, mem_rdata,
`ifdef WB_FWD_EN
    input  fwd_valid, fwd_rd, fwd_data, load_pending,
`endif
    input  in_ready, regwr, rw, busW, misalign_err, timeout_err
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_rd, in_regwr, in_wbsel, in_funct3, in_alu, in_pc4,
    input  mem_rvalid, mem_rdata,
`ifdef WB_FWD_EN
    output fwd_valid, fwd_rd, fwd_data, load_pending,
`endif
    output in_ready, regwr, rw, busW, misalign_err, timeout_err
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: selects ALU / PC+4 / aligned load data and drives the register file from flops.
// Optional macro WB_FWD_EN adds the fwd_valid/fwd_rd/fwd_data/load_pending bypass outputs.
module wb_unit #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input logic      clk,
  input logic      rst_n,
  wb_unit_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [4:0]      ld_rd_reg, ld_rd_next;
  logic [2:0]      ld_f3_reg, ld_f3_next;
  logic [1:0]      ld_addr_reg, ld_addr_next;
  logic            ld_we_reg, ld_we_next;
  logic            regwr_reg, regwr_next;
  logic [4:0]      rw_reg, rw_next;
  logic [XLEN-1:0] busw_reg, busw_next;
  logic            mis_reg, mis_next;
  logic            to_reg, to_next;

  logic            xfer;
  logic            misaligned;
  logic            cnt_done;
  logic [7:0]      lane_byte [4];
  logic [15:0]     lane_half [2];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] ld_data;

  assign bus.in_ready     = (state_reg == IDLE);
  assign xfer             = bus.in_valid && (state_reg == IDLE);
  assign cnt_done         = (cnt_reg == CW'(MAX_WAIT));
  assign bus.regwr        = regwr_reg;
  assign bus.rw           = rw_reg;
  assign bus.busW         = busw_reg;
  assign bus.misalign_err = mis_reg;
  assign bus.timeout_err  = to_reg;

  // Undefined load types are treated as LW, including for alignment.
  always_comb begin
    case (bus.in_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = bus.in_alu[0];
      default:        misaligned = |bus.in_alu[1:0];
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign lane_byte[gi] = bus.mem_rdata[8*gi +: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign lane_half[gi] = bus.mem_rdata[16*gi +: 16];
  end

  assign sel_byte = lane_byte[ld_addr_reg];
  assign sel_half = lane_half[ld_addr_reg[1]];

  always_comb begin
    case (ld_f3_reg)
      3'b000:  ld_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b001:  ld_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, sel_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, sel_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      ld_rd_reg   <= '0;
      ld_f3_reg   <= '0;
      ld_addr_reg <= '0;
      ld_we_reg   <= 1'b0;
      regwr_reg   <= 1'b0;
      rw_reg      <= '0;
      busw_reg    <= '0;
      mis_reg     <= 1'b0;
      to_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ld_rd_reg   <= ld_rd_next;
      ld_f3_reg   <= ld_f3_next;
      ld_addr_reg <= ld_addr_next;
      ld_we_reg   <= ld_we_next;
      regwr_reg   <= regwr_next;
      rw_reg      <= rw_next;
      busw_reg    <= busw_next;
      mis_reg     <= mis_next;
      to_reg      <= to_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          case (bus.in_wbsel)
            2'b00, 2'b10: state_next = WRITE;
            2'b01:        state_next = misaligned ? IDLE : WAIT_MEM;
            default:      state_next = IDLE;
          endcase
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid)  state_next = WRITE;
        else if (cnt_done)   state_next = IDLE;
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // regwr defaults low so it is only ever high for the single cycle spent in WRITE.
  always_comb begin
    regwr_next   = 1'b0;
    rw_next      = rw_reg;
    busw_next    = busw_reg;
    mis_next     = 1'b0;
    to_next      = 1'b0;
    cnt_next     = cnt_reg;
    ld_rd_next   = ld_rd_reg;
    ld_f3_next   = ld_f3_reg;
    ld_addr_next = ld_addr_reg;
    ld_we_next   = ld_we_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          case (bus.in_wbsel)
            2'b00, 2'b10: begin
              rw_next    = bus.in_rd;
              busw_next  = (bus.in_wbsel == 2'b10) ? bus.in_pc4 : bus.in_alu;
              regwr_next = bus.in_regwr && (bus.in_rd != 5'd0);
            end
            2'b01: begin
              if (misaligned) begin
                mis_next = 1'b1;
              end else begin
                ld_rd_next   = bus.in_rd;
                ld_f3_next   = bus.in_funct3;
                ld_addr_next = bus.in_alu[1:0];
                ld_we_next   = bus.in_regwr && (bus.in_rd != 5'd0);
                cnt_next     = '0;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          rw_next    = ld_rd_reg;
          busw_next  = ld_data;
          regwr_next = ld_we_reg;
        end else if (cnt_done) begin
          to_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef WB_FWD_EN
  assign bus.fwd_valid    = (state_reg == WRITE) && regwr_reg;
  assign bus.fwd_rd       = (state_reg == WRITE)    ? rw_reg :
                            (state_reg == WAIT_MEM) ? ld_rd_reg : 5'd0;
  assign bus.fwd_data     = (state_reg == WRITE) ? busw_reg : '0;
  assign bus.load_pending = (state_reg == WAIT_MEM);
`endif

endmodule
